// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for in-flight GPR writes.
// Generates the decode stall / E-bubble and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int LW   = 4,
    parameter int PCW  = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [AW-1:0]   issue_rd,
    input  logic [LW-1:0]   issue_lat,
    input  logic [AW-1:0]   rs_d,
    input  logic [AW-1:0]   rt_d,
    input  logic            use_rs_d,
    input  logic            use_rt_d,
    input  logic            early_d,
    input  logic            pipe_stall,
    input  logic            flush,
    output logic            stall_d,
    output logic            bubble_e,
    output logic [NREG-1:0] busy,
    output logic [PCW-1:0]  stall_cycles
);

    logic [LW-1:0]  cnt_q [NREG];
    logic [LW-1:0]  cnt_d [NREG];
    logic [PCW-1:0] stall_cnt_q;
    logic [PCW-1:0] stall_cnt_d;
    logic [LW-1:0]  rs_cnt;
    logic [LW-1:0]  rt_cnt;
    logic           need_rs;
    logic           need_rt;
    logic           acc;

    // Register 0 never matches the loop, so its source count reads as 0.
    always_comb begin
        rs_cnt = '0;
        rt_cnt = '0;
        for (int r = 1; r < NREG; r++) begin
            if (rs_d == AW'(r)) rs_cnt = cnt_q[r];
            if (rt_d == AW'(r)) rt_cnt = cnt_q[r];
        end
    end

    assign need_rs  = use_rs_d & (early_d ? (rs_cnt != '0) : (rs_cnt > LW'(1)));
    assign need_rt  = use_rt_d & (early_d ? (rt_cnt != '0) : (rt_cnt > LW'(1)));
    assign stall_d  = (need_rs | need_rt) & ~flush;
    assign bubble_e = stall_d & ~pipe_stall;

    assign acc = issue_valid & issue_we & (issue_rd != '0) & (issue_lat != '0)
               & ~stall_d & ~pipe_stall & ~flush;

    always_comb begin
        for (int r = 0; r < NREG; r++) cnt_d[r] = cnt_q[r];
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            if (flush)
                cnt_d[r] = '0;
            else if (pipe_stall)
                cnt_d[r] = cnt_q[r];
            else if (acc && (issue_rd == AW'(r)))
                cnt_d[r] = issue_lat;
            else if (cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - LW'(1);
            else
                cnt_d[r] = cnt_q[r];
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) busy[r] = (cnt_q[r] != '0);
    end

    assign stall_cnt_d  = (stall_d && (stall_cnt_q != '1)) ? stall_cnt_q + PCW'(1) : stall_cnt_q;
    assign stall_cycles = stall_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed latency scenarios then random traffic,
// checked against a timestamp-based readiness model.
module tb_hazard_scoreboard;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int LW   = 4;
    localparam int PCW  = 4;
    localparam int SC_MAX = (1 << PCW) - 1;

    logic            clk = 1'b0;
    logic            resetn;
    logic            issue_valid, issue_we;
    logic [AW-1:0]   issue_rd;
    logic [LW-1:0]   issue_lat;
    logic [AW-1:0]   rs_d, rt_d;
    logic            use_rs_d, use_rt_d, early_d, pipe_stall, flush;
    logic            stall_d, bubble_e;
    logic [NREG-1:0] busy;
    logic [PCW-1:0]  stall_cycles;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .LW(LW), .PCW(PCW)) dut (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd), .issue_lat(issue_lat),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .early_d(early_d),
        .pipe_stall(pipe_stall), .flush(flush),
        .stall_d(stall_d), .bubble_e(bubble_e), .busy(busy), .stall_cycles(stall_cycles)
    );

    int errors = 0;
    int checks = 0;

    // Model: a register is ready once the count of advancing (non-frozen) cycles reaches ready_at.
    int ready_at [NREG];
    int adv;
    int sc;

    function automatic int rem(input int r);
        if (r == 0) return 0;
        return (ready_at[r] > adv) ? ready_at[r] - adv : 0;
    endfunction

    function automatic bit need(input bit u, input int src, input bit early);
        if (!u || src == 0) return 1'b0;
        return early ? (rem(src) >= 1) : (rem(src) >= 2);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        adv = 0;
        sc  = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_we = 0; issue_rd = '0; issue_lat = '0;
        rs_d = '0; rt_d = '0; use_rs_d = 0; use_rt_d = 0; early_d = 0;
        pipe_stall = 0; flush = 0;
    endtask

    task automatic issue(input int rd, input int lat);
        issue_valid = 1; issue_we = 1; issue_rd = AW'(rd); issue_lat = LW'(lat);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
    task automatic cycle(input string tag);
        bit es, eb, acc;
        logic [NREG-1:0] ebusy;
        @(negedge clk);
        es = (need(use_rs_d, int'(rs_d), early_d) || need(use_rt_d, int'(rt_d), early_d)) && !flush;
        eb = es && !pipe_stall;
        for (int r = 0; r < NREG; r++) ebusy[r] = (rem(r) > 0);
        chk({tag, ".stall_d"}, 64'(stall_d), 64'(es));
        chk({tag, ".bubble_e"}, 64'(bubble_e), 64'(eb));
        chk({tag, ".busy"}, 64'(busy), 64'(ebusy));
        chk({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(sc));
        @(posedge clk);
        acc = issue_valid && issue_we && (issue_rd != 0) && (issue_lat != 0) && !es && !pipe_stall && !flush;
        if (flush) begin
            for (int r = 0; r < NREG; r++) ready_at[r] = 0;
        end else if (!pipe_stall) begin
            adv++;
            if (acc) ready_at[issue_rd] = adv + int'(issue_lat);
        end
        if (es && sc < SC_MAX) sc++;
        #1;
    endtask

    initial begin
        idle();
        resetn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall_d", 64'(stall_d), 64'd0);
        chk("reset.bubble_e", 64'(bubble_e), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.stall_cycles", 64'(stall_cycles), 64'd0);
        resetn = 1;
        cycle("settle");

        // ALU r3 then dependent normal consumer: no stall, busy[3] for one cycle
        issue(3, 1); cycle("alu_iss");
        idle(); use_rs_d = 1; rs_d = 5'd3;
        chk("alu.busy3_pre", 64'(busy[3]), 64'd1);
        cycle("alu_use");
        idle(); cycle("alu_after");
        chk("alu.busy3_post", 64'(busy[3]), 64'd0);
        chk("alu.sc", 64'(stall_cycles), 64'd0);

        // Load r5 then rt consumer: one stall cycle
        issue(5, 2); cycle("ld_iss");
        idle(); use_rt_d = 1; rt_d = 5'd5;
        repeat (3) cycle("ld_use");
        chk("ld.sc", 64'(stall_cycles), 64'd1);

        // Load r5 then early branch on r5: two stall cycles
        idle(); issue(5, 2); cycle("ldbr_iss");
        idle(); use_rs_d = 1; rs_d = 5'd5; early_d = 1;
        repeat (4) cycle("ldbr_use");
        chk("ldbr.sc", 64'(stall_cycles), 64'd3);

        // Div r8 lat 6 with a two-cycle back-end freeze: seven stall cycles
        idle(); issue(8, 6); cycle("div_iss");
        idle(); use_rs_d = 1; rs_d = 5'd8;
        for (int k = 1; k <= 10; k++) begin
            pipe_stall = (k == 2 || k == 3);
            cycle("div_use");
        end
        chk("div.sc", 64'(stall_cycles), 64'd10);

        // Div r8 flushed while its consumer waits
        idle(); issue(8, 6); cycle("fl_iss");
        idle(); use_rs_d = 1; rs_d = 5'd8;
        cycle("fl_use");
        flush = 1; cycle("fl_flush");
        flush = 0;
        chk("fl.busy", 64'(busy), 64'd0);
        cycle("fl_after");
        chk("fl.sc", 64'(stall_cycles), 64'd11);

        // Write to r0 is ignored
        idle(); issue(0, 5); cycle("r0_iss");
        idle(); use_rs_d = 1; rs_d = 5'd0; early_d = 1;
        chk("r0.busy", 64'(busy), 64'd0);
        cycle("r0_use");

        // WAW reload of r4 while its counter is at 1
        idle(); issue(4, 3); cycle("waw_iss1");
        idle(); cycle("waw_w1"); cycle("waw_w2");
        issue(4, 3); cycle("waw_iss2");
        idle();
        for (int k = 0; k < 3; k++) begin
            chk("waw.busy4_held", 64'(busy[4]), 64'd1);
            cycle("waw_hold");
        end
        chk("waw.busy4_clear", 64'(busy[4]), 64'd0);

        // Random traffic, including stall-counter saturation
        for (int n = 0; n < 600; n++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_we    = ($urandom_range(0, 4) != 0);
            issue_rd    = AW'($urandom_range(0, 7));
            issue_lat   = LW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
            rs_d        = AW'($urandom_range(0, 7));
            rt_d        = AW'($urandom_range(0, 7));
            use_rs_d    = $urandom_range(0, 1);
            use_rt_d    = $urandom_range(0, 1);
            early_d     = ($urandom_range(0, 3) == 0);
            pipe_stall  = ($urandom_range(0, 6) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            cycle("rnd");
        end

        // Asynchronous reset mid-cycle clears state without a clock edge
        idle(); issue(6, 9); cycle("ar_iss");
        #2 resetn = 0;
        #1;
        chk("areset.busy", 64'(busy), 64'd0);
        chk("areset.stall_cycles", 64'(stall_cycles), 64'd0);
        model_reset();
        resetn = 1;
        idle(); cycle("ar_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage hazard logic.
- Keeps a per-register countdown scoreboard of in-flight writes, so variable-latency producers (ALU, load, multi-cycle div/mul, future units) are handled from one latency code instead of per-stage compare terms.
- Sits beside decode and generates the decode stall and E-bubble. Forward-mux selects stay in the existing forwarding logic.
- Also keeps a stall performance counter.

Parameters:
- NREG, 32, number of architectural GPRs tracked (register 0 hardwired ready).
- AW, 5, register index width; NREG <= 2^AW.
- LW, 4, latency counter width; largest legal issue latency is 2^LW-1.
- PCW, 32, stall performance counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction in D is presented for issue to E this cycle.
- issue_we  in  1  issuing instruction writes a GPR.
- issue_rd  in  AW  destination register of the issuing instruction.
- issue_lat  in  LW  cycles after issue until the result is forwardable to an E-stage consumer. ALU=1, load=2, div=N. 0 means no tracking.
- rs_d  in  AW  source register A of the instruction in D.
- rt_d  in  AW  source register B of the instruction in D.
- use_rs_d  in  1  the D instruction reads rs_d.
- use_rt_d  in  1  the D instruction reads rt_d.
- early_d  in  1  the D instruction resolves in D (branch/jr), so operands are needed one stage earlier.
- pipe_stall  in  1  global back-end freeze (if/mem/div long stall).
- flush  in  1  exception flush from M.
- stall_d  out  1  hold F and D.
- bubble_e  out  1  insert a bubble into E.
- busy  out  NREG  bitmap; bit r=1 when cnt[r]!=0.
- stall_cycles  out  PCW  saturating count of cycles with stall_d=1.

Behaviour:
- Reset (async, resetn=0): every cnt[r]=0, stall_cycles=0. Consequently stall_d=0, bubble_e=0, busy=0.
- State: cnt[r], LW bits per register. cnt[0] is constant 0.
- Source-not-ready rule: need(src) = use & src!=0 & (early_d ? cnt[src]!=0 : cnt[src]>1).
  - This is evaluated combinationally from the current counters (read before the same-cycle write).
- stall_d = (need(rs_d) | need(rt_d)) & ~flush.
- bubble_e = stall_d & ~pipe_stall.
- Accept condition: acc = issue_valid & issue_we & issue_rd!=0 & issue_lat!=0 & ~stall_d & ~pipe_stall & ~flush.
- Per-cycle counter update, in priority order:
  1. flush=1: all cnt cleared to 0 next cycle, regardless of pipe_stall or issue.
  2. pipe_stall=1: all cnt hold.
  3. Otherwise: cnt[issue_rd] <= issue_lat if acc. Every other nonzero cnt decrements by 1. The issued register's load wins over its own decrement.
- Resulting latencies:
  - ALU (lat=1) producer to dependent normal consumer: 0 stall cycles.
  - Load (lat=2) producer to normal consumer: 1 stall cycle.
  - ALU producer to early consumer: 1 stall cycle.
  - Load producer to early consumer: 2 stall cycles.
  - lat=N producer: N-1 stall cycles (normal consumer) or N (early consumer), plus any pipe_stall cycles.
- WAW: a new accepted write to a busy register overwrites its counter.
- stall_cycles: increments when stall_d=1 and it is below its maximum; holds at 2^PCW-1.
- Outputs are purely combinational from state and inputs. There is no added pipeline latency.

Test Plan:
- ALU write r3 (lat=1), next D reads r3 with use_rs_d=1, early_d=0 -> stall_d=0 every cycle; busy[3]=1 for exactly 1 cycle.
- Load r5 (lat=2), next D reads rt=r5 -> stall_d=1 and bubble_e=1 for 1 cycle, then 0; stall_cycles=1.
- Load r5, next D is a branch (early_d=1) on r5 -> stall_d=1 for 2 cycles.
- Div r8 (lat=6), consumer in D, pipe_stall=1 for cycles 2-3 -> stall_d high for 7 cycles; bubble_e=0 while pipe_stall=1; cnt frozen across the freeze.
- Div r8 (lat=6), flush at cycle 2 -> busy=0 next cycle and stall_d=0; also, stall_d stays 0 in any cycle where flush=1.
- Write to r0 with lat=5 -> busy=0 and no stall. Also: issue r4 lat=3 while cnt[4]=1, with same-cycle decrement -> cnt[4]=3; busy[4] stays set for 3 more cycles.
